// File: rtl/dmem_responder.sv
// dmem_responder: data-memory end of the core's load/store port.
// One request at a time, fixed wait latency, little-endian byte/half/word
// accesses, registered load data and a one-cycle Ready completion pulse.
module dmem_responder #(
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  input  logic [1:0]  Size,
  input  logic        Unsigned,
  output logic [31:0] ReadData,
  output logic        Ready,
  output logic        Err,
  output logic        Busy
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int DEPTH = 1 << ADDR_W;

  // Illegal request: conflicting type, reserved size or misaligned access.
  function automatic logic reqError(input logic rd, input logic wr,
                                    input logic [1:0] size, input logic [1:0] lowAddr);
    logic e;
    e = 1'b0;
    case (size)
      2'b00:   e = 1'b0;
      2'b01:   e = lowAddr[0];
      2'b10:   e = (lowAddr != 2'b00);
      default: e = 1'b1;
    endcase
    return e | (rd & wr);
  endfunction

  state_t              state_r, nextState_s;
  logic [3:0]          cnt_r, nextCnt_s;
  logic                accept_s, doneEntry_s, liveEntry_s;
  logic [ADDR_W-1:0]   addr_r, opAddr_s, a1_s, a2_s, a3_s;
  logic [31:0]         wdata_r, opWdata_s;
  logic [1:0]          size_r, opSize_s;
  logic                uns_r, opUns_s, wr_r, opWrite_s, reqErr_r, opErr_s;
  logic [7:0]          b0_s, b1_s, b2_s, b3_s;
  logic [31:0]         loadData_s, readData_r;
  logic                ready_r, errOut_r, busy_r;
  logic [7:0]          mem_r [0:DEPTH-1];
  logic                unusedAddrBits_s;

  // Upper address bits alias onto the storage window.
  assign unusedAddrBits_s = ^Addr[31:ADDR_W];

  assign accept_s    = (state_r != WAIT) && (MemRead || MemWrite);
  assign doneEntry_s = (nextState_s == DONE);
  // With a one-cycle latency DONE is entered straight from acceptance, so the
  // access must use the live request rather than the latched copy.
  assign liveEntry_s = accept_s && doneEntry_s;

  assign opAddr_s  = liveEntry_s ? Addr[ADDR_W-1:0] : addr_r;
  assign opWdata_s = liveEntry_s ? WriteData : wdata_r;
  assign opSize_s  = liveEntry_s ? Size : size_r;
  assign opUns_s   = liveEntry_s ? Unsigned : uns_r;
  assign opWrite_s = liveEntry_s ? MemWrite : wr_r;
  assign opErr_s   = liveEntry_s ? reqError(MemRead, MemWrite, Size, Addr[1:0]) : reqErr_r;

  assign a1_s = opAddr_s + ADDR_W'(1);
  assign a2_s = opAddr_s + ADDR_W'(2);
  assign a3_s = opAddr_s + ADDR_W'(3);
  assign b0_s = mem_r[opAddr_s];
  assign b1_s = mem_r[a1_s];
  assign b2_s = mem_r[a2_s];
  assign b3_s = mem_r[a3_s];

  // Next-state and wait-counter logic.
  always_comb begin
    nextState_s = state_r;
    nextCnt_s   = cnt_r;
    case (state_r)
      IDLE, DONE: begin
        if (accept_s) begin
          if (LATENCY == 1) begin
            nextState_s = DONE;
          end else begin
            nextState_s = WAIT;
            nextCnt_s   = 4'(LATENCY - 2);
          end
        end else begin
          nextState_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r == 4'd0) begin
          nextState_s = DONE;
        end else begin
          nextCnt_s = cnt_r - 4'd1;
        end
      end
      default: nextState_s = IDLE;
    endcase
  end

  // Little-endian load assembly with sign/zero extension.
  always_comb begin
    loadData_s = 32'h0000_0000;
    case (opSize_s)
      2'b00: loadData_s = opUns_s ? {24'h00_0000, b0_s} : {{24{b0_s[7]}}, b0_s};
      2'b01: loadData_s = opUns_s ? {16'h0000, b1_s, b0_s} : {{16{b1_s[7]}}, b1_s, b0_s};
      2'b10: loadData_s = {b3_s, b2_s, b1_s, b0_s};
      default: loadData_s = 32'h0000_0000;
    endcase
  end

  // State, counter and latched request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r  <= IDLE;
      cnt_r    <= 4'd0;
      addr_r   <= '0;
      wdata_r  <= 32'h0000_0000;
      size_r   <= 2'b00;
      uns_r    <= 1'b0;
      wr_r     <= 1'b0;
      reqErr_r <= 1'b0;
    end else begin
      state_r <= nextState_s;
      cnt_r   <= nextCnt_s;
      if (accept_s) begin
        addr_r   <= Addr[ADDR_W-1:0];
        wdata_r  <= WriteData;
        size_r   <= Size;
        uns_r    <= Unsigned;
        wr_r     <= MemWrite;
        reqErr_r <= reqError(MemRead, MemWrite, Size, Addr[1:0]);
      end
    end
  end

  // Legal stores commit on DONE entry; storage itself is never reset.
  always_ff @(posedge clk) begin
    if (rst_n && doneEntry_s && opWrite_s && !opErr_s) begin
      case (opSize_s)
        2'b00: mem_r[opAddr_s] <= opWdata_s[7:0];
        2'b01: begin
          mem_r[opAddr_s] <= opWdata_s[7:0];
          mem_r[a1_s]     <= opWdata_s[15:8];
        end
        2'b10: begin
          mem_r[opAddr_s] <= opWdata_s[7:0];
          mem_r[a1_s]     <= opWdata_s[15:8];
          mem_r[a2_s]     <= opWdata_s[23:16];
          mem_r[a3_s]     <= opWdata_s[31:24];
        end
        default: ;
      endcase
    end
  end

  // Registered completion outputs; data/status held until the next DONE entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_r    <= 1'b0;
      busy_r     <= 1'b0;
      errOut_r   <= 1'b0;
      readData_r <= 32'h0000_0000;
    end else begin
      ready_r <= doneEntry_s;
      busy_r  <= (nextState_s != IDLE);
      if (doneEntry_s) begin
        errOut_r   <= opErr_s;
        readData_r <= (opErr_s || opWrite_s) ? 32'h0000_0000 : loadData_s;
      end
    end
  end

  assign ReadData = readData_r;
  assign Ready    = ready_r;
  assign Err      = errOut_r;
  assign Busy     = busy_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vector table, multi-cycle
// corner sequences, a one-cycle-latency instance and a random run against a
// byte-array reference model.
module tb_dmem_responder;

  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        MemRead, MemWrite, Unsigned;
  logic [31:0] Addr, WriteData, ReadData;
  logic [1:0]  Size;
  logic        Ready, Err, Busy;

  logic        rd1, wr1, uns1, ready1, err1, busy1;
  logic [31:0] addr1, wd1, rdata1;
  logic [1:0]  size1;

  int nCmp = 0;
  int nBad = 0;
  logic [7:0] refMem [256];

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(8), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .MemRead(MemRead), .MemWrite(MemWrite),
    .Addr(Addr), .WriteData(WriteData), .Size(Size), .Unsigned(Unsigned),
    .ReadData(ReadData), .Ready(Ready), .Err(Err), .Busy(Busy));

  dmem_responder #(.ADDR_W(8), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .MemRead(rd1), .MemWrite(wr1),
    .Addr(addr1), .WriteData(wd1), .Size(size1), .Unsigned(uns1),
    .ReadData(rdata1), .Ready(ready1), .Err(err1), .Busy(busy1));

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [1:0]  sz;
    logic        un;
    logic [31:0] expData;
    logic        expErr;
  } vec_t;

  vec_t tbl[15];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Caller is at a negedge; drive, let the next posedge accept, wait for Ready.
  task automatic xact(input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] wd, input logic [1:0] sz, input logic un,
                      output logic [31:0] data, output logic err, output int lat);
    MemRead = rd; MemWrite = wr; Addr = a; WriteData = wd; Size = sz; Unsigned = un;
    @(posedge clk);
    @(negedge clk);
    MemRead = 1'b0; MemWrite = 1'b0;
    lat = 1;
    while (!Ready && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    data = ReadData;
    err  = Err;
  endtask

  // Reference behaviour from the access rules, on a flat 256-byte array.
  task automatic model(input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] wd, input logic [1:0] sz, input logic un,
                       output logic [31:0] data, output logic err);
    int base, n;
    longint v;
    base = int'(a & 32'h0000_00FF);
    n    = 1 << sz;
    err  = (rd && wr) || (sz == 2'd3) || (sz == 2'd1 && base % 2 != 0) ||
           (sz == 2'd2 && base % 4 != 0);
    data = 32'h0;
    if (!err && wr) begin
      for (int i = 0; i < n; i++) refMem[(base + i) % 256] = 8'(wd >> (8 * i));
    end else if (!err && rd) begin
      v = 0;
      for (int i = 0; i < n; i++) v += longint'(refMem[(base + i) % 256]) << (8 * i);
      if (n < 4 && !un && v >= (longint'(1) << (8 * n - 1))) v -= (longint'(1) << (8 * n));
      data = 32'(v);
    end
  endtask

  initial begin
    logic [31:0] d, ed, a, wd;
    logic        e, ee, rd, wr, un;
    logic [1:0]  sz;
    int          lat, cnt, r;

    tbl[0]  = '{1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 2'd2, 1'b0, 32'h0,        1'b0};
    tbl[1]  = '{1'b1, 1'b0, 32'h10,  32'h0,        2'd2, 1'b0, 32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 32'h13,  32'h0,        2'd0, 1'b0, 32'hFFFFFFDE, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 32'h13,  32'h0,        2'd0, 1'b1, 32'h000000DE, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 32'h12,  32'h0,        2'd1, 1'b0, 32'hFFFFDEAD, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 32'h10,  32'h0,        2'd1, 1'b1, 32'h0000BEEF, 1'b0};
    tbl[6]  = '{1'b0, 1'b1, 32'h11,  32'h7F,       2'd0, 1'b0, 32'h0,        1'b0};
    tbl[7]  = '{1'b1, 1'b0, 32'h10,  32'h0,        2'd2, 1'b0, 32'hDEAD7FEF, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 32'h110, 32'h0,        2'd2, 1'b0, 32'hDEAD7FEF, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 32'h12,  32'h0,        2'd2, 1'b0, 32'h0,        1'b1};
    tbl[10] = '{1'b1, 1'b0, 32'h11,  32'h0,        2'd1, 1'b0, 32'h0,        1'b1};
    tbl[11] = '{1'b1, 1'b0, 32'h10,  32'h0,        2'd3, 1'b0, 32'h0,        1'b1};
    tbl[12] = '{1'b1, 1'b1, 32'h10,  32'h0,        2'd2, 1'b0, 32'h0,        1'b1};
    tbl[13] = '{1'b0, 1'b1, 32'h11,  32'hFFFF,     2'd1, 1'b0, 32'h0,        1'b1};
    tbl[14] = '{1'b1, 1'b0, 32'h10,  32'h0,        2'd2, 1'b0, 32'hDEAD7FEF, 1'b0};

    rst_n = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Addr = 32'h0; WriteData = 32'h0;
    Size = 2'd0; Unsigned = 1'b0;
    rd1 = 1'b0; wr1 = 1'b0; addr1 = 32'h0; wd1 = 32'h0; size1 = 2'd0; uns1 = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset Ready", 32'(Ready), 32'h0);
    check("reset Busy", 32'(Busy), 32'h0);
    check("reset Err", 32'(Err), 32'h0);
    check("reset ReadData", ReadData, 32'h0);

    // Directed vector table, one idle cycle between requests.
    foreach (tbl[i]) begin
      @(negedge clk);
      xact(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wd, tbl[i].sz, tbl[i].un, d, e, lat);
      check($sformatf("vec%0d latency", i), 32'(lat), 32'(LAT));
      check($sformatf("vec%0d data", i), d, tbl[i].expData);
      check($sformatf("vec%0d err", i), 32'(e), 32'(tbl[i].expErr));
    end

    // Request held through WAIT is ignored: exactly one Ready.
    @(negedge clk);
    MemRead = 1'b1; Addr = 32'h10; Size = 2'd2; Unsigned = 1'b0;
    @(negedge clk);
    check("wait Busy", 32'(Busy), 32'h1);
    check("wait Ready", 32'(Ready), 32'h0);
    Addr = 32'h13; Size = 2'd0;
    @(negedge clk);
    MemRead = 1'b0;
    check("wait done Ready", 32'(Ready), 32'h1);
    check("wait done data", ReadData, 32'hDEAD7FEF);
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (Ready) cnt++;
    end
    check("wait extra Ready", 32'(cnt), 32'h0);

    // Requests presented in the DONE cycle are accepted back-to-back.
    xact(1'b1, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, d, e, lat);
    check("b2b first data", d, 32'hDEAD7FEF);
    xact(1'b1, 1'b0, 32'h13, 32'h0, 2'd0, 1'b1, d, e, lat);
    check("b2b second latency", 32'(lat), 32'(LAT));
    check("b2b second data", d, 32'h000000DE);
    xact(1'b1, 1'b0, 32'h12, 32'h0, 2'd1, 1'b0, d, e, lat);
    check("b2b third latency", 32'(lat), 32'(LAT));
    check("b2b third data", d, 32'hFFFFDEAD);

    // Reset during WAIT of a store drops it.
    @(negedge clk);
    MemWrite = 1'b1; Addr = 32'h10; WriteData = 32'h0; Size = 2'd2;
    @(negedge clk);
    MemWrite = 1'b0;
    check("rst pre Busy", 32'(Busy), 32'h1);
    rst_n = 1'b0;
    #1;
    check("rst Ready", 32'(Ready), 32'h0);
    check("rst Busy", 32'(Busy), 32'h0);
    check("rst ReadData", ReadData, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (Ready) cnt++;
    end
    check("rst no Ready", 32'(cnt), 32'h0);
    xact(1'b1, 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, d, e, lat);
    check("rst store dropped", d, 32'hDEAD7FEF);

    // One-cycle latency instance: Ready every cycle for continuous requests.
    @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      if (k < 4) begin
        rd1 = 1'b0; wr1 = 1'b1; addr1 = 32'(4 * k); wd1 = 32'(32'h11111111 * (k + 1));
      end else begin
        rd1 = 1'b1; wr1 = 1'b0; addr1 = 32'(4 * (k - 4)); wd1 = 32'h0;
      end
      size1 = 2'd2;
      @(negedge clk);
      check($sformatf("lat1 Ready %0d", k), 32'(ready1), 32'h1);
      check($sformatf("lat1 data %0d", k), rdata1,
            (k < 4) ? 32'h0 : 32'(32'h11111111 * (k - 3)));
    end
    rd1 = 1'b0; wr1 = 1'b0;
    @(negedge clk);
    check("lat1 idle Ready", 32'(ready1), 32'h0);

    // Fill storage through the model so every byte is defined.
    for (int w = 0; w < 64; w++) begin
      wd = $urandom;
      model(1'b0, 1'b1, 32'(4 * w), wd, 2'd2, 1'b0, ed, ee);
      @(negedge clk);
      xact(1'b0, 1'b1, 32'(4 * w), wd, 2'd2, 1'b0, d, e, lat);
      check("fill latency", 32'(lat), 32'(LAT));
      check("fill err", 32'(e), 32'(ee));
    end

    // Random mix, sometimes back-to-back in the DONE cycle.
    for (int t = 0; t < 150; t++) begin
      r  = $urandom_range(0, 9);
      rd = (r == 0) || (r > 4);
      wr = (r <= 4);
      sz = 2'($urandom_range(0, 3));
      a  = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      wd = $urandom;
      un = 1'($urandom_range(0, 1));
      model(rd, wr, a, wd, sz, un, ed, ee);
      if ($urandom_range(0, 1) != 0) @(negedge clk);
      xact(rd, wr, a, wd, sz, un, d, e, lat);
      check($sformatf("rand%0d latency", t), 32'(lat), 32'(LAT));
      check($sformatf("rand%0d data", t), d, ed);
      check($sformatf("rand%0d err", t), 32'(e), 32'(ee));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the RISC-V core: the memory-side end of the load/store interface driven by the control unit (`MemRead`/`MemWrite`) and ALU address path. It accepts one request at a time, inserts a fixed configurable wait latency, performs byte/half/word accesses little-endian, and returns a one-cycle `Ready` pulse with registered, extended load data. It replaces the zero-latency data memory when the core moves to a multicycle/stalling datapath.

## Interface
- `ADDR_W`, 8: byte-address width; storage is 2^ADDR_W bytes.
- `LATENCY`, 2: cycles from request acceptance to `Ready`; legal range 1..15.
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `MemRead` input 1: load request.
- `MemWrite` input 1: store request.
- `Addr` input 32: byte address; only `Addr[ADDR_W-1:0]` used, upper bits ignored (wrap).
- `WriteData` input 32: store data, low bytes used for byte/half.
- `Size` input 2: 00 byte, 01 half, 10 word, 11 illegal.
- `Unsigned` input 1: 1 = zero-extend loads, 0 = sign-extend.
- `ReadData` output 32: load result, registered.
- `Ready` output 1: one-cycle completion pulse.
- `Err` output 1: completion status, valid only with `Ready`.
- `Busy` output 1: high in WAIT and DONE.

## Operation
- FSM states: IDLE, WAIT, DONE. Reset state IDLE.
- Acceptance: on a rising edge in IDLE or DONE with `MemRead|MemWrite` = 1, latch `Addr`, `WriteData`, `Size`, `Unsigned`, and request type. Requests in WAIT are ignored (not queued).
- On accept: if LATENCY = 1, go to DONE; else load counter with LATENCY-2, go to WAIT.
- WAIT: counter 0 → DONE; else decrement.
- DONE: `Ready` = 1 for exactly this cycle. A new accepted request goes to WAIT/DONE as above; otherwise IDLE.
- Error: `MemRead` and `MemWrite` both high, `Size` = 11, half at odd address, or word with `Addr[1:0]` ≠ 0 → request still completes after LATENCY with `Err` = 1; no storage write; `ReadData` = 0.
- Store: bytes written on the edge entering DONE; byte writes `Addr`, half writes `Addr`/`Addr+1`, word `Addr..Addr+3`, LSB at lowest address.
- Load: data read and extended on the edge entering DONE. Byte: bit 7 extended; half: bit 15 extended; word: unchanged. `Unsigned` ignored for word.
- Store completion: `ReadData` = 0, `Err` = 0.
- `ReadData`/`Err` hold their value until the next DONE entry.
- Storage contents not reset; undefined until written.

## Timing
- Reset values: `Ready` 0, `Err` 0, `Busy` 0, `ReadData` 0, state IDLE, counter 0.
- Request sampled at edge E0 → `Ready` high between edges E0+LATENCY-1 and E0+LATENCY, i.e. visible LATENCY cycles after acceptance.
- Back-to-back throughput: one request per LATENCY cycles when requests are presented in the DONE cycle.
- Store-then-load to the same address issued back-to-back returns the newly stored data.
- Reset asserted mid-operation: immediate IDLE, outputs to reset values, pending store dropped.
- Requester must hold request signals stable only during the acceptance cycle.

## Test plan
- LATENCY=2: SW `0xDEADBEEF` at 0x10, then LW 0x10 → each `Ready` 2 cycles after accept; `ReadData` = 0xDEADBEEF, `Err` = 0.
- LB at 0x13 → 0xFFFFFFDE; LBU 0x13 → 0x000000DE; LH 0x12 → 0xFFFFDEAD; LHU 0x10 → 0x0000BEEF.
- SB 0x7F at 0x11, then LW 0x10 → 0xDEAD7FEF; `Addr` = 0x00000110 with ADDR_W=8 aliases to 0x10 → same result.
- LW at 0x12, LH at 0x11, `Size`=11, and both `MemRead`/`MemWrite` → `Ready` after LATENCY, `Err` = 1, `ReadData` = 0; following LW 0x10 shows memory unchanged.
- Request asserted during WAIT → ignored, exactly one `Ready`; request in DONE cycle → accepted, next `Ready` 2 cycles later; LATENCY=1 build → `Ready` every cycle for continuous requests.
- `rst_n` low during WAIT of a SW 0x0 to 0x10 → `Ready`/`Busy` 0 immediately, no `Ready` afterwards; LW 0x10 then returns prior value 0xDEAD7FEF.
